// File: rtl/axi_wr_master.sv
// Single-beat AXI4 write master for the memory-stage store path.
// Accepts one store request, issues AW/W, waits for B, then pulses completion.
module axi_wr_master #(
  parameter int unsigned     ID_W  = 4,
  parameter logic [ID_W-1:0] WR_ID = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mm_wen,
  input  logic [63:0]     mm_addr,
  input  logic [63:0]     mm_wdata,
  input  logic [3:0]      mm_wlen,
  output logic            mm_wbusy,
  output logic            mm_wdone,
  output logic            mm_werr,
  output logic [ID_W-1:0] AWID,
  output logic [63:0]     AWADDR,
  output logic [7:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [63:0]     WDATA,
  output logic [7:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [63:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        werr_q, werr_d;

  logic        lenOk;
  logic [2:0]  sizeEnc;
  logic [2:0]  alignMask;
  logic [7:0]  strbBase;
  logic        reqLegal;

  // Decode the byte length into AXI size, alignment mask and base strobe.
  always_comb begin
    lenOk     = 1'b1;
    sizeEnc   = 3'd0;
    alignMask = 3'b000;
    strbBase  = 8'h01;
    case (mm_wlen)
      4'd1: begin sizeEnc = 3'd0; alignMask = 3'b000; strbBase = 8'h01; end
      4'd2: begin sizeEnc = 3'd1; alignMask = 3'b001; strbBase = 8'h03; end
      4'd4: begin sizeEnc = 3'd2; alignMask = 3'b011; strbBase = 8'h0F; end
      4'd8: begin sizeEnc = 3'd3; alignMask = 3'b111; strbBase = 8'hFF; end
      default: lenOk = 1'b0;
    endcase
    reqLegal = lenOk && ((mm_addr[2:0] & alignMask) == 3'b000);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      werr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      werr_q    <= werr_d;
    end
  end

  // AW and W retire independently; RESP is entered once neither is pending.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    werr_d    = werr_q;
    case (state_q)
      IDLE: begin
        if (mm_wen) begin
          if (reqLegal) begin
            awaddr_d  = mm_addr;
            awsize_d  = sizeEnc;
            wdata_d   = mm_wdata << {mm_addr[2:0], 3'b000};
            wstrb_d   = strbBase << mm_addr[2:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            werr_d    = 1'b0;
            state_d   = REQ;
          end else begin
            werr_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (AWREADY) awvalid_d = 1'b0;
        if (WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = RESP;
      end
      RESP: begin
        if (BVALID) begin
          werr_d  = (BRESP != 2'b00) || (BID != WR_ID);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mm_wbusy = (state_q == REQ) || (state_q == RESP) || ((state_q == IDLE) && mm_wen);
  assign mm_wdone = (state_q == DONE);
  assign mm_werr  = (state_q == DONE) && werr_q;

  assign AWID    = WR_ID;
  assign AWADDR  = awaddr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = awsize_q;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = (state_q == RESP);

endmodule

// File: tb/tb_axi_wr_master.sv
// Scoreboard bench for axi_wr_master: stimulus pushes expectations,
// a negedge monitor pops and compares as the DUT presents AW, W and completion.
module tb_axi_wr_master;

  localparam int         ID_W  = 4;
  localparam logic [3:0] WR_ID = 4'd0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mm_wen = 1'b0;
  logic [63:0] mm_addr = '0;
  logic [63:0] mm_wdata = '0;
  logic [3:0]  mm_wlen = '0;
  logic        mm_wbusy, mm_wdone, mm_werr;
  logic [3:0]  AWID;
  logic [63:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID;
  logic        WREADY = 1'b0;
  logic [3:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;

  axi_wr_master #(.ID_W(ID_W), .WR_ID(WR_ID)) dut (
    .clk(clk), .rstn(rstn),
    .mm_wen(mm_wen), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_wlen(mm_wlen),
    .mm_wbusy(mm_wbusy), .mm_wdone(mm_wdone), .mm_werr(mm_werr),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [2:0] size; } awExp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } wExp_t;
  typedef struct { logic err; int cycle; } doneExp_t;

  awExp_t   awQ[$];
  wExp_t    wQ[$];
  doneExp_t doneQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int awCount = 0;
  int wCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshakes and completions are matched against the queues.
  logic        awWait = 1'b0, wWait = 1'b0;
  logic [63:0] awAddrPrev = '0, wDataPrev = '0;
  logic [7:0]  wStrbPrev = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      awWait = 1'b0;
      wWait  = 1'b0;
    end else begin
      if (awWait) checkOutput("awHoldStable", {AWVALID, AWADDR[62:0]}, {1'b1, awAddrPrev[62:0]});
      if (wWait)  checkOutput("wHoldStable", {WVALID, WSTRB, WDATA[54:0]}, {1'b1, wStrbPrev, wDataPrev[54:0]});
      if (AWVALID && awQ.size() == 0) begin
        checkOutput("awUnexpected", 64'(AWVALID), 64'd0);
      end else if (AWVALID && AWREADY) begin
        awExp_t e;
        e = awQ.pop_front();
        awCount++;
        checkOutput("awAddr", AWADDR, e.addr);
        checkOutput("awSize", 64'(AWSIZE), 64'(e.size));
        checkOutput("awFixed", {AWID, AWLEN, AWBURST}, {WR_ID, 8'd0, 2'b01});
      end
      if (WVALID && wQ.size() == 0) begin
        checkOutput("wUnexpected", 64'(WVALID), 64'd0);
      end else if (WVALID && WREADY) begin
        wExp_t e;
        e = wQ.pop_front();
        wCount++;
        checkOutput("wData", WDATA, e.data);
        checkOutput("wStrbLast", {WSTRB, WLAST}, {e.strb, 1'b1});
      end
      if (mm_wdone) begin
        if (doneQ.size() == 0) begin
          checkOutput("doneUnexpected", 64'(mm_wdone), 64'd0);
        end else begin
          doneExp_t e;
          e = doneQ.pop_front();
          checkOutput("werr", 64'(mm_werr), 64'(e.err));
          checkOutput("doneCycle", 64'(cyc), 64'(e.cycle));
        end
      end
      awWait     = AWVALID && !AWREADY;
      awAddrPrev = AWADDR;
      wWait      = WVALID && !WREADY;
      wDataPrev  = WDATA;
      wStrbPrev  = WSTRB;
    end
  end

  // One store: reference expectations from the byte-lane rules, then a
  // slave that answers with the requested delays and response.
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                               input logic [3:0] len, input int awD, input int wD,
                               input int bD, input logic [1:0] bresp, input logic [3:0] bid);
    int       off, ilen, c, rcnt, start, awBefore, wBefore;
    bit       legal, done, busyOk;
    awExp_t   ea;
    wExp_t    ew;
    doneExp_t ed;
    off  = int'(addr[2:0]);
    ilen = int'(len);
    legal = (ilen == 1 || ilen == 2 || ilen == 4 || ilen == 8);
    if (legal) legal = (off % ilen) == 0;
    @(posedge clk); #1;
    start = cyc;
    awBefore = awCount;
    wBefore  = wCount;
    if (legal) begin
      ea.addr = addr;
      ea.size = 3'($clog2(ilen));
      ew.data = data << (8 * off);
      for (int i = 0; i < 8; i++) ew.strb[i] = (i >= off) && (i < off + ilen);
      awQ.push_back(ea);
      wQ.push_back(ew);
      ed.err   = (bresp != 2'b00) || (bid != WR_ID);
      ed.cycle = start + ((awD > wD) ? awD : wD) + 1 + 1 + bD + 1;
    end else begin
      ed.err   = 1'b1;
      ed.cycle = start + 1;
    end
    doneQ.push_back(ed);
    mm_wen = 1'b1; mm_addr = addr; mm_wdata = data; mm_wlen = len;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = bresp; BID = bid;
    c = 0; rcnt = 0; done = 1'b0; busyOk = 1'b1;
    while (!done && c < 200) begin
      @(negedge clk);
      if (mm_wdone) begin
        done = 1'b1;
        if (mm_wbusy) busyOk = 1'b0;
      end else if (!mm_wbusy) begin
        busyOk = 1'b0;
      end
      @(posedge clk); #1;
      c++;
      AWREADY = (c >= 1 + awD);
      WREADY  = (c >= 1 + wD);
      if (BREADY) begin
        rcnt++;
        BVALID = (rcnt > bD);
      end else begin
        BVALID = 1'b0;
      end
    end
    mm_wen = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    if (!done) checkOutput("doneTimeout", 64'(done), 64'd1);
    checkOutput("busyProfile", 64'(busyOk), 64'd1);
    checkOutput("awIssued", 64'(awCount - awBefore), legal ? 64'd1 : 64'd0);
    checkOutput("wIssued", 64'(wCount - wBefore), legal ? 64'd1 : 64'd0);
  endtask

  initial begin
    automatic logic [3:0] lenTab[11] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5};
    logic [63:0] rAddr, rData;
    logic [3:0]  rLen;
    logic [1:0]  rResp;
    logic [3:0]  rId;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValids", {AWVALID, WVALID, BREADY, mm_wdone, mm_werr}, 64'd0);
    checkOutput("rstAddr", AWADDR, 64'd0);
    checkOutput("rstData", WDATA, 64'd0);
    checkOutput("rstStrbSize", {WSTRB, AWSIZE}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    applyStimulus(64'h8000_0010, 64'h1122_3344_5566_7788, 4'd8, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus(64'h8000_0005, 64'h0000_0000_0000_00AB, 4'd1, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus(64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 4'd4, 3, 0, 0, 2'b00, 4'd0);
    applyStimulus(64'h8000_0003, 64'h0000_0000_0000_1234, 4'd2, 0, 0, 0, 2'b00, 4'd0);
    applyStimulus(64'h8000_0020, 64'hCAFE_F00D_0BAD_BEEF, 4'd8, 0, 0, 0, 2'b10, 4'd0);
    applyStimulus(64'h8000_0028, 64'h0123_4567_89AB_CDEF, 4'd8, 0, 0, 0, 2'b00, 4'd3);
    applyStimulus(64'h8000_0002, 64'h0000_0000_0000_5A5A, 4'd2, 0, 2, 3, 2'b00, 4'd0);

    for (int n = 0; n < 40; n++) begin
      rLen  = lenTab[$urandom_range(0, 10)];
      rAddr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0 && (rLen == 4'd1 || rLen == 4'd2 || rLen == 4'd4 || rLen == 4'd8))
        rAddr[2:0] = rAddr[2:0] & ~(3'(rLen - 4'd1));
      rData = {$urandom, $urandom};
      rResp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rId   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      applyStimulus(rAddr, rData, rLen, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), rResp, rId);
    end

    // Abort a write in flight: no completion may follow.
    @(posedge clk); #1;
    mm_wen = 1'b1; mm_addr = 64'h8000_0008; mm_wdata = 64'h1; mm_wlen = 4'd8;
    AWREADY = 1'b0; WREADY = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortPreValid", {AWVALID, WVALID}, 64'd3);
    rstn = 1'b0;
    mm_wen = 1'b0;
    awQ.delete(); wQ.delete(); doneQ.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("abortOutputs", {AWVALID, WVALID, BREADY, mm_wdone, mm_wbusy}, 64'd0);
    AWREADY = 1'b1; WREADY = 1'b1;
    repeat (5) @(negedge clk);
    AWREADY = 1'b0; WREADY = 1'b0;

    applyStimulus(64'h8000_0040, 64'h7766_5544_3322_1100, 4'd8, 1, 1, 1, 2'b00, 4'd0);

    repeat (4) @(negedge clk);
    checkOutput("queuesDrained", 64'(awQ.size() + wQ.size() + doneQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_wr_master.md
Name: axi_wr_master

Overview:
- AXI4 write-channel master (AW/W/B) for the memory-access stage's store path.
- Takes one store request per instruction (address, data, byte length, enable) and issues a single-beat AXI write.
- Stalls the pipeline until the write response returns, then reports completion and error status.
- Sits directly downstream of the memory-access stage, alongside the existing AXI read interface.

Parameters:
- WR_ID, 4'd0, constant value driven on AWID; BID is checked against it.
- ID_W, 4, width of AWID/BID.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- mm_wen  in  1  store request from memory stage; held stable while mm_wbusy=1
- mm_addr  in  64  store byte address
- mm_wdata  in  64  store data, right-aligned (LSB = first byte)
- mm_wlen  in  4  store length in bytes; legal values 1, 2, 4, 8
- mm_wbusy  out  1  stall request to pipeline
- mm_wdone  out  1  one-cycle completion pulse
- mm_werr  out  1  error flag, valid only when mm_wdone=1
- AWID  out  ID_W  write ID, always WR_ID
- AWADDR  out  64  write address
- AWLEN  out  8  burst length, always 0
- AWSIZE  out  3  log2(len)
- AWBURST  out  2  burst type, always 2'b01 (INCR)
- AWVALID  out  1  address valid
- AWREADY  in  1  address ready
- WDATA  out  64  write data, lane-aligned
- WSTRB  out  8  byte strobes
- WLAST  out  1  last beat, always 1
- WVALID  out  1  data valid
- WREADY  in  1  data ready
- BID  in  ID_W  response ID
- BRESP  in  2  write response
- BVALID  in  1  response valid
- BREADY  out  1  response ready

Behaviour:
- Clock and reset: clk, synchronous active-low rstn.
- Reset values: state=IDLE; AWVALID=WVALID=BREADY=0; mm_wdone=mm_werr=0; AWADDR=WDATA=0; WSTRB=0; AWSIZE=0.
- Reset mid-transaction aborts to IDLE with no completion pulse.
- States: IDLE, REQ, RESP, DONE.
- mm_wbusy is combinational: 1 in REQ and RESP, 1 in IDLE when mm_wen=1, 0 in DONE.
- Legality check, in IDLE:
  - Request is legal iff mm_wlen ∈ {1,2,4,8} and (mm_addr[2:0] & (mm_wlen-1)) == 0, i.e. naturally aligned.
- IDLE, mm_wen=1, legal:
  - Register AWADDR=mm_addr; AWSIZE = 0/1/2/3 for len 1/2/4/8.
  - Register WDATA = mm_wdata << (8*mm_addr[2:0]).
  - Register WSTRB = ((1<<len)-1) << mm_addr[2:0], truncated to 8 bits.
  - Assert AWVALID=WVALID=1; go to REQ.
- IDLE, mm_wen=1, illegal: no AXI traffic; go to DONE with werr_pending=1.
- REQ:
  - AWVALID and WVALID are each held until their own handshake (VALID&READY), then dropped the next cycle independently.
  - AW and W may complete in the same cycle or in either order.
  - VALID never drops before its handshake.
  - Address and data stay stable while VALID=1.
  - When both handshakes are done, go to RESP with BREADY=1. If the second handshake completes this cycle, RESP is entered next cycle.
- RESP:
  - BREADY=1. On BVALID: werr_pending = (BRESP!=2'b00) | (BID!=WR_ID). BREADY=0; go to DONE.
- DONE, one cycle:
  - mm_wdone=1, mm_werr=werr_pending, mm_wbusy=0; the pipeline advances on this edge.
  - mm_wen is ignored in DONE, which guarantees no re-issue of the held request. Next state IDLE.
- Minimum latency: mm_wen in IDLE (cycle 0), AW/W handshake cycle 1, BVALID cycle 2, mm_wdone cycle 3.
- mm_wen=0 in IDLE: stay idle; all outputs keep their last data and VALIDs stay 0.
- Back-pressure of any length on AWREADY, WREADY or BVALID only extends REQ or RESP; there is no timeout.

Test Plan:
- sd at addr 0x8000_0010, data 0x1122334455667788, len 8, AWREADY=WREADY=1, BVALID one cycle later with OKAY:
  - WSTRB=0xFF, AWSIZE=3, WDATA unchanged.
  - mm_wdone at cycle 3, mm_werr=0, mm_wbusy high cycles 0-2.
- sb at addr 0x8000_0005, data 0xAB, len 1:
  - WSTRB=0x20, WDATA=0x0000AB0000000000, AWSIZE=0.
- sw at 0x8000_0004 with AWREADY delayed 3 cycles and WREADY immediate:
  - WVALID drops after cycle 1; AWVALID held 4 cycles with AWADDR stable.
  - WSTRB=0xF0, single mm_wdone.
- sh at 0x8000_0003 (misaligned), len 2:
  - No AWVALID/WVALID ever asserted.
  - mm_wdone=1 with mm_werr=1 the cycle after the request.
- BRESP=SLVERR (2'b10) on an sd: mm_werr=1 with mm_wdone. Repeat with BID≠WR_ID: mm_werr=1.
- mm_wen held high across DONE by the bench:
  - Exactly one AXI write is issued.
  - rstn asserted while in REQ: next cycle AWVALID=WVALID=0 and state IDLE, with no mm_wdone.
